// File: rtl/branch_target_unit_pkg.sv
// ----------------------------------------------------------------------------
// branch_target_unit_pkg
//
// Pipeline-wide constants used by the control-flow target logic.
//   OP_*   : RV32 major opcodes (inst[6:0]) for the three control-flow forms.
//   KIND_* : encoding carried on tgt_kind toward the PC-select mux.
// ----------------------------------------------------------------------------
package branch_target_unit_pkg;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] KIND_NONE = 2'b00;
   localparam logic [1:0] KIND_JAL  = 2'b01;
   localparam logic [1:0] KIND_JALR = 2'b10;
   localparam logic [1:0] KIND_BR   = 2'b11;

endpackage

// File: rtl/branch_target_unit_btb_dm.sv
// ----------------------------------------------------------------------------
// btb_dm - direct-mapped branch target buffer
//
// Holds DEPTH entries of {valid, tag, target}, indexed by pc[IDXW+1:2].
// Lookups are registered (1-cycle latency). Updates from EX are written on
// the same edge that registers a lookup, so a lookup and an update to the
// same index in one cycle return the old contents.
//
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   flush           : suppresses the lookup response being registered
//   lk_valid, lk_pc : lookup request from IF
//   lk_resp_valid   : registered lookup response valid
//   lk_hit          : registered hit flag
//   lk_target       : registered predicted target (0 on miss)
//   up_valid        : update strobe from EX
//   up_pc           : resolved instruction PC
//   up_target       : resolved target
//   up_taken        : 1 installs/overwrites, 0 invalidates on tag match
// ----------------------------------------------------------------------------
module btb_dm
   import branch_target_unit_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            lk_valid,
   input  logic [XLEN-1:0] lk_pc,
   output logic            lk_resp_valid,
   output logic            lk_hit,
   output logic [XLEN-1:0] lk_target,
   input  logic            up_valid,
   input  logic [XLEN-1:0] up_pc,
   input  logic [XLEN-1:0] up_target,
   input  logic            up_taken
);

   localparam int IDXW = $clog2(DEPTH);
   localparam int TAGW = XLEN - IDXW - 2;

   logic [DEPTH-1:0] valid_q;
   logic [TAGW-1:0]  tag_q  [DEPTH];
   logic [XLEN-1:0]  data_q [DEPTH];

   logic [IDXW-1:0]  lk_idx;
   logic [TAGW-1:0]  lk_tag;
   logic [IDXW-1:0]  up_idx;
   logic [TAGW-1:0]  up_tag;
   logic             lk_hit_d;
   logic             unused_pc_bits;

   // Instructions are word aligned, so the two low PC bits never select an
   // entry; they are gathered here only so they are visibly consumed.
   assign unused_pc_bits = ^{lk_pc[1:0], up_pc[1:0]};

   assign lk_idx = lk_pc[IDXW+1:2];
   assign lk_tag = lk_pc[XLEN-1:IDXW+2];
   assign up_idx = up_pc[IDXW+1:2];
   assign up_tag = up_pc[XLEN-1:IDXW+2];

   // Hit is judged against the array contents before this edge's update,
   // which is what gives read-before-write behaviour for same-index traffic.
   always_comb begin
      lk_hit_d = lk_valid & ~flush & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
   end

   // Lookup response register. Target is forced to zero on a miss so the
   // PC-select mux never sees stale data alongside lk_hit=0.
   always_ff @(posedge clk) begin
      if (rst) begin
         lk_resp_valid <= 1'b0;
         lk_hit        <= 1'b0;
         lk_target     <= '0;
      end else begin
         lk_resp_valid <= lk_valid & ~flush;
         lk_hit        <= lk_hit_d;
         lk_target     <= lk_hit_d ? data_q[lk_idx] : '0;
      end
   end

   // Valid bits are the only state that must be cleared on reset. A
   // not-taken resolution only evicts the entry if it belongs to this PC,
   // otherwise an unrelated alias would be thrown away.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (up_valid) begin
         if (up_taken) begin
            valid_q[up_idx] <= 1'b1;
         end else if (tag_q[up_idx] == up_tag) begin
            valid_q[up_idx] <= 1'b0;
         end
      end
   end

   // Tag and target arrays carry no reset; entries are only meaningful
   // while their valid bit is set.
   always_ff @(posedge clk) begin
      if (!rst && up_valid && up_taken) begin
         tag_q[up_idx]  <= up_tag;
         data_q[up_idx] <= up_target;
      end
   end

endmodule

// File: rtl/branch_target_unit.sv
// ----------------------------------------------------------------------------
// branch_target_unit
//
// Computes control-flow targets for JAL, JALR and B-type branches from the
// decode stage (registered, 1-cycle latency) and hosts a direct-mapped BTB
// used by IF for next-PC prediction.
//
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   flush             : pipeline redirect, kills in-flight decode/lookup
//   dec_valid         : decode instruction valid
//   dec_pc            : decode instruction PC
//   dec_inst          : decode instruction word
//   dec_rs1           : forwarded rs1 (JALR base)
//   tgt_valid         : registered target valid
//   tgt_addr          : registered target address
//   tgt_kind          : 00 none, 01 jal, 10 jalr, 11 branch
//   tgt_misalign      : target bit 1 set (no compressed ISA)
//   lk_valid, lk_pc   : BTB lookup request
//   lk_resp_valid     : BTB lookup response valid
//   lk_hit, lk_target : BTB hit and predicted target
//   up_valid, up_pc, up_target, up_taken : BTB update from EX
// ----------------------------------------------------------------------------
module branch_target_unit
   import branch_target_unit_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            dec_valid,
   input  logic [XLEN-1:0] dec_pc,
   input  logic [31:0]     dec_inst,
   input  logic [XLEN-1:0] dec_rs1,
   output logic            tgt_valid,
   output logic [XLEN-1:0] tgt_addr,
   output logic [1:0]      tgt_kind,
   output logic            tgt_misalign,
   input  logic            lk_valid,
   input  logic [XLEN-1:0] lk_pc,
   output logic            lk_resp_valid,
   output logic            lk_hit,
   output logic [XLEN-1:0] lk_target,
   input  logic            up_valid,
   input  logic [XLEN-1:0] up_pc,
   input  logic [XLEN-1:0] up_target,
   input  logic            up_taken
);

   logic [1:0]      kind_d;
   logic [XLEN-1:0] imm_j;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] addr_d;
   logic            misalign_d;

   // Classify the instruction. JALR is only recognised with funct3=000;
   // other funct3 values under that opcode are not control flow.
   always_comb begin
      kind_d = KIND_NONE;
      if (dec_inst[6:0] == OP_JAL) begin
         kind_d = KIND_JAL;
      end else if (dec_inst[6:0] == OP_JALR && dec_inst[14:12] == 3'b000) begin
         kind_d = KIND_JALR;
      end else if (dec_inst[6:0] == OP_BRANCH) begin
         kind_d = KIND_BR;
      end
   end

   assign imm_j = {{(XLEN-21){dec_inst[31]}}, dec_inst[31], dec_inst[19:12],
                   dec_inst[20], dec_inst[30:21], 1'b0};
   assign imm_b = {{(XLEN-13){dec_inst[31]}}, dec_inst[31], dec_inst[7],
                   dec_inst[30:25], dec_inst[11:8], 1'b0};
   assign imm_i = {{(XLEN-12){dec_inst[31]}}, dec_inst[31:20]};
   assign jalr_sum = dec_rs1 + imm_i;

   // Target adders wrap modulo 2^XLEN. JALR clears bit 0 but keeps bit 1,
   // so a bit-1 target surfaces as a misalignment exception request.
   always_comb begin
      addr_d = '0;
      case (kind_d)
         KIND_JAL:  addr_d = dec_pc + imm_j;
         KIND_BR:   addr_d = dec_pc + imm_b;
         KIND_JALR: addr_d = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};
         default:   addr_d = '0;
      endcase
      misalign_d = (kind_d != KIND_NONE) & addr_d[1];
   end

   // Decode-side target register. Payload only loads on a live decode slot
   // so downstream logic keeps the last real target while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         tgt_valid    <= 1'b0;
         tgt_addr     <= '0;
         tgt_kind     <= KIND_NONE;
         tgt_misalign <= 1'b0;
      end else begin
         tgt_valid <= dec_valid & (kind_d != KIND_NONE) & ~flush;
         if (dec_valid && !flush) begin
            tgt_addr     <= addr_d;
            tgt_kind     <= kind_d;
            tgt_misalign <= misalign_d;
         end
      end
   end

   btb_dm #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_btb (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .lk_valid      (lk_valid),
      .lk_pc         (lk_pc),
      .lk_resp_valid (lk_resp_valid),
      .lk_hit        (lk_hit),
      .lk_target     (lk_target),
      .up_valid      (up_valid),
      .up_pc         (up_pc),
      .up_target     (up_target),
      .up_taken      (up_taken)
   );

endmodule

// File: tb/tb_branch_target_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_target_unit
//
// Directed bench for branch_target_unit with hand-computed expectations.
// Inputs change 1 time unit after each rising edge; outputs are checked
// at the same point, after the edge that registered them.
// ----------------------------------------------------------------------------
module tb_branch_target_unit;

   localparam int XLEN  = 32;
   localparam int DEPTH = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic            dec_valid;
   logic [XLEN-1:0] dec_pc;
   logic [31:0]     dec_inst;
   logic [XLEN-1:0] dec_rs1;
   logic            tgt_valid;
   logic [XLEN-1:0] tgt_addr;
   logic [1:0]      tgt_kind;
   logic            tgt_misalign;
   logic            lk_valid;
   logic [XLEN-1:0] lk_pc;
   logic            lk_resp_valid;
   logic            lk_hit;
   logic [XLEN-1:0] lk_target;
   logic            up_valid;
   logic [XLEN-1:0] up_pc;
   logic [XLEN-1:0] up_target;
   logic            up_taken;

   int testCount = 0;
   int failCount = 0;

   branch_target_unit #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .dec_valid     (dec_valid),
      .dec_pc        (dec_pc),
      .dec_inst      (dec_inst),
      .dec_rs1       (dec_rs1),
      .tgt_valid     (tgt_valid),
      .tgt_addr      (tgt_addr),
      .tgt_kind      (tgt_kind),
      .tgt_misalign  (tgt_misalign),
      .lk_valid      (lk_valid),
      .lk_pc         (lk_pc),
      .lk_resp_valid (lk_resp_valid),
      .lk_hit        (lk_hit),
      .lk_target     (lk_target),
      .up_valid      (up_valid),
      .up_pc         (up_pc),
      .up_target     (up_target),
      .up_taken      (up_taken)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Advance one clock and settle just past the rising edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // Single comparison point: counts it, and on mismatch counts and reports.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Directed sequence: reset, decode targets, BTB install/hit/evict,
   // flush and mid-run reset.
   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      dec_valid = 1'b0;
      dec_pc    = '0;
      dec_inst  = '0;
      dec_rs1   = '0;
      lk_valid  = 1'b0;
      lk_pc     = '0;
      up_valid  = 1'b0;
      up_pc     = '0;
      up_target = '0;
      up_taken  = 1'b0;

      applyStimulus();
      applyStimulus();
      checkOutput("rst_tgt_valid", 32'(tgt_valid), 32'd0);
      checkOutput("rst_tgt_addr", tgt_addr, 32'd0);
      checkOutput("rst_tgt_kind", 32'(tgt_kind), 32'd0);
      checkOutput("rst_tgt_misalign", 32'(tgt_misalign), 32'd0);
      checkOutput("rst_lk_resp_valid", 32'(lk_resp_valid), 32'd0);
      checkOutput("rst_lk_hit", 32'(lk_hit), 32'd0);
      checkOutput("rst_lk_target", lk_target, 32'd0);

      rst = 1'b0;

      // jal x1,+8 at 0x100
      dec_valid = 1'b1; dec_pc = 32'h100; dec_inst = 32'h008000EF;
      applyStimulus();
      checkOutput("jal_fwd_valid", 32'(tgt_valid), 32'd1);
      checkOutput("jal_fwd_kind", 32'(tgt_kind), 32'd1);
      checkOutput("jal_fwd_addr", tgt_addr, 32'h108);
      checkOutput("jal_fwd_mis", 32'(tgt_misalign), 32'd0);

      // jal x0,-4 at 0x200
      dec_pc = 32'h200; dec_inst = 32'hFFDFF06F;
      applyStimulus();
      checkOutput("jal_back_addr", tgt_addr, 32'h1FC);
      checkOutput("jal_back_kind", 32'(tgt_kind), 32'd1);

      // beq -8 at 0x40
      dec_pc = 32'h40; dec_inst = 32'hFE000CE3;
      applyStimulus();
      checkOutput("beq_addr", tgt_addr, 32'h38);
      checkOutput("beq_kind", 32'(tgt_kind), 32'd3);
      checkOutput("beq_valid", 32'(tgt_valid), 32'd1);

      // jalr +5 from 0x1000: bit 0 cleared
      dec_pc = 32'h300; dec_inst = 32'h005100E7; dec_rs1 = 32'h1000;
      applyStimulus();
      checkOutput("jalr5_addr", tgt_addr, 32'h1004);
      checkOutput("jalr5_kind", 32'(tgt_kind), 32'd2);
      checkOutput("jalr5_mis", 32'(tgt_misalign), 32'd0);

      // jalr +7 from 0x1000: bit 1 survives -> misaligned
      dec_inst = 32'h007100E7;
      applyStimulus();
      checkOutput("jalr7_addr", tgt_addr, 32'h1006);
      checkOutput("jalr7_mis", 32'(tgt_misalign), 32'd1);

      // jalr +5 from 0xFFFFFFFF wraps
      dec_inst = 32'h005100E7; dec_rs1 = 32'hFFFF_FFFF;
      applyStimulus();
      checkOutput("jalr_wrap_addr", tgt_addr, 32'h4);
      checkOutput("jalr_wrap_mis", 32'(tgt_misalign), 32'd0);

      // idle decode: valid drops, payload holds
      dec_valid = 1'b0; dec_inst = 32'h008000EF; dec_pc = 32'h500;
      applyStimulus();
      checkOutput("idle_valid", 32'(tgt_valid), 32'd0);
      checkOutput("idle_hold_addr", tgt_addr, 32'h4);
      checkOutput("idle_hold_kind", 32'(tgt_kind), 32'd2);

      // jalr opcode with funct3=001 is not control flow
      dec_valid = 1'b1; dec_inst = 32'h005110E7; dec_rs1 = 32'h1000;
      applyStimulus();
      checkOutput("jalr_f3_valid", 32'(tgt_valid), 32'd0);
      checkOutput("jalr_f3_kind", 32'(tgt_kind), 32'd0);

      // addi: kind none, no misalign
      dec_inst = 32'h00000013;
      applyStimulus();
      checkOutput("addi_valid", 32'(tgt_valid), 32'd0);
      checkOutput("addi_mis", 32'(tgt_misalign), 32'd0);
      dec_valid = 1'b0;

      // install 0x80 -> 0x200
      up_valid = 1'b1; up_pc = 32'h80; up_target = 32'h200; up_taken = 1'b1;
      applyStimulus();
      checkOutput("no_lk_resp", 32'(lk_resp_valid), 32'd0);
      up_valid = 1'b0;

      lk_valid = 1'b1; lk_pc = 32'h80;
      applyStimulus();
      checkOutput("hit80_resp", 32'(lk_resp_valid), 32'd1);
      checkOutput("hit80_hit", 32'(lk_hit), 32'd1);
      checkOutput("hit80_target", lk_target, 32'h200);

      // same index, different tag
      lk_pc = 32'h80 + 32'(4 * DEPTH);
      applyStimulus();
      checkOutput("alias_resp", 32'(lk_resp_valid), 32'd1);
      checkOutput("alias_hit", 32'(lk_hit), 32'd0);
      checkOutput("alias_target", lk_target, 32'd0);

      // not-taken update on alias tag must not evict 0x80
      lk_valid = 1'b0;
      up_valid = 1'b1; up_pc = 32'h80 + 32'(4 * DEPTH); up_taken = 1'b0;
      applyStimulus();
      up_valid = 1'b0;
      lk_valid = 1'b1; lk_pc = 32'h80;
      applyStimulus();
      checkOutput("alias_nt_keep_hit", 32'(lk_hit), 32'd1);

      // not-taken on 0x80 evicts it
      lk_valid = 1'b0;
      up_valid = 1'b1; up_pc = 32'h80; up_taken = 1'b0;
      applyStimulus();
      up_valid = 1'b0;
      lk_valid = 1'b1; lk_pc = 32'h80;
      applyStimulus();
      checkOutput("evict_hit", 32'(lk_hit), 32'd0);

      // same-cycle lookup and install: old (miss) result, then hit
      up_valid = 1'b1; up_pc = 32'h80; up_target = 32'h300; up_taken = 1'b1;
      applyStimulus();
      checkOutput("rbw_resp", 32'(lk_resp_valid), 32'd1);
      checkOutput("rbw_hit", 32'(lk_hit), 32'd0);
      checkOutput("rbw_target", lk_target, 32'd0);
      up_valid = 1'b0;
      applyStimulus();
      checkOutput("rbw_next_hit", 32'(lk_hit), 32'd1);
      checkOutput("rbw_next_target", lk_target, 32'h300);

      // second entry at index 1
      lk_valid = 1'b0;
      up_valid = 1'b1; up_pc = 32'h84; up_target = 32'h500; up_taken = 1'b1;
      applyStimulus();
      up_valid = 1'b0;
      lk_valid = 1'b1; lk_pc = 32'h84;
      applyStimulus();
      checkOutput("hit84_hit", 32'(lk_hit), 32'd1);
      checkOutput("hit84_target", lk_target, 32'h500);

      // flush kills decode and lookup responses
      flush = 1'b1; dec_valid = 1'b1; dec_pc = 32'h100; dec_inst = 32'h008000EF;
      lk_pc = 32'h80;
      applyStimulus();
      checkOutput("flush_tgt_valid", 32'(tgt_valid), 32'd0);
      checkOutput("flush_lk_resp", 32'(lk_resp_valid), 32'd0);
      checkOutput("flush_lk_hit", 32'(lk_hit), 32'd0);
      flush = 1'b0; dec_valid = 1'b0;
      applyStimulus();
      checkOutput("post_flush_hit", 32'(lk_hit), 32'd1);
      checkOutput("post_flush_target", lk_target, 32'h300);

      // reset mid-run with live requests
      rst = 1'b1; dec_valid = 1'b1;
      applyStimulus();
      checkOutput("rst2_tgt_valid", 32'(tgt_valid), 32'd0);
      checkOutput("rst2_tgt_addr", tgt_addr, 32'd0);
      checkOutput("rst2_tgt_kind", 32'(tgt_kind), 32'd0);
      checkOutput("rst2_lk_resp", 32'(lk_resp_valid), 32'd0);
      checkOutput("rst2_lk_target", lk_target, 32'd0);
      rst = 1'b0; dec_valid = 1'b0;
      lk_pc = 32'h80;
      applyStimulus();
      checkOutput("rst2_miss80_resp", 32'(lk_resp_valid), 32'd1);
      checkOutput("rst2_miss80_hit", 32'(lk_hit), 32'd0);
      lk_pc = 32'h84;
      applyStimulus();
      checkOutput("rst2_miss84_hit", 32'(lk_hit), 32'd0);
      checkOutput("rst2_miss84_target", lk_target, 32'd0);

      lk_valid = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
